// File: rtl/regfile_pkg.sv
// Shared defines for the register file: bus widths, register count,
// enable polarities and the read-port selection rule.
package regfile_pkg;

  localparam int RegBus       = 16;
  localparam int RegAddrBus   = 4;
  localparam int RegNum       = 16;
  localparam int NumReadPorts = 2;

  localparam logic [RegBus-1:0] ZeroWord    = '0;
  localparam logic              WriteEnable = 1'b1;
  localparam logic              ReadEnable  = 1'b1;

  // Reset, a disabled port and r0 all outrank the write bypass.
  function automatic logic [RegBus-1:0] read_port(
    input logic                  rst,
    input logic                  re,
    input logic [RegAddrBus-1:0] raddr,
    input logic                  bypass_hit,
    input logic [RegBus-1:0]     wdata,
    input logic [RegBus-1:0]     stored
  );
    if (rst || (re != ReadEnable) || (raddr == '0)) begin
      return ZeroWord;
    end
    if (bypass_hit) begin
      return wdata;
    end
    return stored;
  endfunction

endpackage

// File: rtl/regfile.sv
// 16 x 16-bit register file, one write port and two combinational read ports.
// Optional same-cycle write-to-read bypass is enabled with macro REGFILE_BYPASS_EN.
module regfile
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [RegBus-1:0]     wdata,
  input  logic                  re1,
  input  logic [RegAddrBus-1:0] raddr1,
  output logic [RegBus-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata2
);

`ifdef REGFILE_BYPASS_EN
  localparam logic BypassEn = 1'b1;
`else
  localparam logic BypassEn = 1'b0;
`endif

  logic [RegBus-1:0] regs_reg [RegNum];
  logic [RegNum-1:0] wsel;

  genvar gi;

  // r0 never gets a write select, so it holds the value reset gave it.
  generate
    for (gi = 0; gi < RegNum; gi++) begin : g_wsel
      if (gi == 0) begin : g_r0
        assign wsel[gi] = 1'b0;
      end else begin : g_rn
        assign wsel[gi] = (we == WriteEnable) && (waddr == RegAddrBus'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < RegNum; i++) begin
      if (rst) begin
        regs_reg[i] <= ZeroWord;
      end else if (wsel[i]) begin
        regs_reg[i] <= wdata;
      end
    end
  end

  logic [NumReadPorts-1:0]                 re_vec;
  logic [NumReadPorts-1:0][RegAddrBus-1:0] raddr_vec;
  logic [NumReadPorts-1:0][RegBus-1:0]     rdata_vec;

  assign re_vec    = {re2, re1};
  assign raddr_vec = {raddr2, raddr1};

  generate
    for (gi = 0; gi < NumReadPorts; gi++) begin : g_rport
      logic bypass_hit;

      assign bypass_hit = BypassEn && (we == WriteEnable) &&
                          (waddr == raddr_vec[gi]) && (waddr != '0);

      assign rdata_vec[gi] = read_port(rst, re_vec[gi], raddr_vec[gi], bypass_hit,
                                       wdata, regs_reg[raddr_vec[gi]]);
    end
  endgenerate

  assign rdata1 = rdata_vec[0];
  assign rdata2 = rdata_vec[1];

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: expectations are queued as stimulus is
// driven and compared against the read ports before the next rising edge.
module tb_regfile;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        re1;
  logic [3:0]  raddr1;
  logic [15:0] rdata1;
  logic        re2;
  logic [3:0]  raddr2;
  logic [15:0] rdata2;

  always #5 clk = ~clk;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  typedef struct {
    string       name;
    int          port;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] model [16];

  task automatic drive_idle();
    rst = 1'b0; we = 1'b0; waddr = 4'h0; wdata = 16'h0000;
    re1 = 1'b0; raddr1 = 4'h0; re2 = 1'b0; raddr2 = 4'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // Write r3, reset across it (including a write offered during reset).
  task automatic test_reset();
    exp_t e;
    logic [15:0] got;
    for (int ph = 0; ph < 6; ph++) begin
      next_cycle();
      case (ph)
        0: begin rst = 1; re1 = 1; raddr1 = 4'd3;
                 sb_q.push_back('{"rst_power_on", 1, 16'h0000}); end
        1: begin we = 1; waddr = 4'd3; wdata = 16'h1234; re2 = 1; raddr2 = 4'd3;
                 sb_q.push_back('{"rst_pre_write_re_off", 1, 16'h0000});
                 sb_q.push_back('{"rst_pre_write_same_cycle", 2, BYP ? 16'h1234 : 16'h0000}); end
        2: begin re1 = 1; raddr1 = 4'd3;
                 sb_q.push_back('{"rst_pre_read_r3", 1, 16'h1234}); end
        3: begin rst = 1; re1 = 1; raddr1 = 4'd3; we = 1; waddr = 4'd3; wdata = 16'hBEEF;
                 re2 = 1; raddr2 = 4'd3;
                 sb_q.push_back('{"rst_hold_c1_p1", 1, 16'h0000});
                 sb_q.push_back('{"rst_hold_c1_p2", 2, 16'h0000}); end
        4: begin rst = 1; re1 = 1; raddr1 = 4'd3;
                 sb_q.push_back('{"rst_hold_c2", 1, 16'h0000}); end
        default: begin re1 = 1; raddr1 = 4'd3;
                 sb_q.push_back('{"rst_release_r3", 1, 16'h0000}); end
      endcase
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = (e.port == 1) ? rdata1 : rdata2;
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata%0d=%h, want %h", e.name, e.port, got, e.exp);
        end else $display("ok   %s: rdata%0d=%h", e.name, e.port, got);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [15:0] got;
    for (int ph = 0; ph < 3; ph++) begin
      next_cycle();
      case (ph)
        0: begin we = 1; waddr = 4'd1; wdata = 16'h0008; end
        1: begin re1 = 1; raddr1 = 4'd1;
                 sb_q.push_back('{"wr_rd_r1", 1, 16'h0008}); end
        default: begin re1 = 0; raddr1 = 4'd1;
                 sb_q.push_back('{"wr_rd_re_off", 1, 16'h0000}); end
      endcase
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = (e.port == 1) ? rdata1 : rdata2;
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata%0d=%h, want %h", e.name, e.port, got, e.exp);
        end else $display("ok   %s: rdata%0d=%h", e.name, e.port, got);
      end
    end
  endtask

  task automatic test_r0();
    exp_t e;
    logic [15:0] got;
    for (int ph = 0; ph < 2; ph++) begin
      next_cycle();
      case (ph)
        0: begin we = 1; waddr = 4'd0; wdata = 16'hFFFF; re2 = 1; raddr2 = 4'd0;
                 sb_q.push_back('{"r0_same_cycle", 2, 16'h0000}); end
        default: begin re2 = 1; raddr2 = 4'd0; re1 = 1; raddr1 = 4'd0;
                 sb_q.push_back('{"r0_next_p2", 2, 16'h0000});
                 sb_q.push_back('{"r0_next_p1", 1, 16'h0000}); end
      endcase
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = (e.port == 1) ? rdata1 : rdata2;
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata%0d=%h, want %h", e.name, e.port, got, e.exp);
        end else $display("ok   %s: rdata%0d=%h", e.name, e.port, got);
      end
    end
  endtask

  task automatic test_hazard();
    exp_t e;
    logic [15:0] got;
    for (int ph = 0; ph < 3; ph++) begin
      next_cycle();
      case (ph)
        0: begin we = 1; waddr = 4'd2; wdata = 16'h0004; end
        1: begin we = 1; waddr = 4'd2; wdata = 16'h0010; re1 = 1; raddr1 = 4'd2;
                 re2 = 0; raddr2 = 4'd2;
                 sb_q.push_back('{"hazard_same_cycle", 1, BYP ? 16'h0010 : 16'h0004});
                 sb_q.push_back('{"hazard_re_off_wins", 2, 16'h0000}); end
        default: begin re1 = 1; raddr1 = 4'd2;
                 sb_q.push_back('{"hazard_next_cycle", 1, 16'h0010}); end
      endcase
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = (e.port == 1) ? rdata1 : rdata2;
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata%0d=%h, want %h", e.name, e.port, got, e.exp);
        end else $display("ok   %s: rdata%0d=%h", e.name, e.port, got);
      end
    end
  endtask

  task automatic test_dual_read();
    exp_t e;
    logic [15:0] got;
    for (int ph = 0; ph < 4; ph++) begin
      next_cycle();
      case (ph)
        0: begin we = 1; waddr = 4'd1; wdata = 16'h0004; end
        1: begin we = 1; waddr = 4'd2; wdata = 16'h0005; end
        2: begin re1 = 1; raddr1 = 4'd1; re2 = 1; raddr2 = 4'd2;
                 sb_q.push_back('{"dual_p1_r1", 1, 16'h0004});
                 sb_q.push_back('{"dual_p2_r2", 2, 16'h0005}); end
        default: begin re1 = 1; raddr1 = 4'd2; re2 = 1; raddr2 = 4'd2;
                 sb_q.push_back('{"dual_same_p1", 1, 16'h0005});
                 sb_q.push_back('{"dual_same_p2", 2, 16'h0005}); end
      endcase
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = (e.port == 1) ? rdata1 : rdata2;
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata%0d=%h, want %h", e.name, e.port, got, e.exp);
        end else $display("ok   %s: rdata%0d=%h", e.name, e.port, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] got;
    for (int ph = 0; ph < 3; ph++) begin
      next_cycle();
      re2 = 1; raddr2 = 4'd6;
      sb_q.push_back('{"b2b_r6_untouched", 2, 16'h0000});
      case (ph)
        0: begin we = 1; waddr = 4'd5; wdata = 16'hAAAA; end
        1: begin we = 1; waddr = 4'd5; wdata = 16'h5555; end
        default: begin re1 = 1; raddr1 = 4'd5;
                 sb_q.push_back('{"b2b_r5_last_wins", 1, 16'h5555}); end
      endcase
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = (e.port == 1) ? rdata1 : rdata2;
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata%0d=%h, want %h", e.name, e.port, got, e.exp);
        end else $display("ok   %s: rdata%0d=%h", e.name, e.port, got);
      end
    end
  endtask

  // Random traffic against a reference array, starting from a reset.
  task automatic test_random();
    exp_t e;
    logic [15:0] got;
    logic [15:0] ex1, ex2;
    for (int c = 0; c < 80; c++) begin
      next_cycle();
      if (c == 0) begin
        rst = 1;
      end else begin
        rst    = ($urandom_range(0, 24) == 0);
        we     = ($urandom_range(0, 2) != 0);
        waddr  = 4'($urandom_range(0, 15));
        wdata  = 16'($urandom);
        re1    = ($urandom_range(0, 4) != 0);
        raddr1 = 4'($urandom_range(0, 15));
        re2    = ($urandom_range(0, 4) != 0);
        raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      end
      ex1 = 16'h0000;
      ex2 = 16'h0000;
      if (!rst && re1 && raddr1 != 4'd0)
        ex1 = (BYP && we && waddr == raddr1) ? wdata : model[raddr1];
      if (!rst && re2 && raddr2 != 4'd0)
        ex2 = (BYP && we && waddr == raddr2) ? wdata : model[raddr2];
      sb_q.push_back('{"rand_p1", 1, ex1});
      sb_q.push_back('{"rand_p2", 2, ex2});
      if (rst) begin
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      end else if (we && waddr != 4'd0) begin
        model[waddr] = wdata;
      end
      @(negedge clk);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = (e.port == 1) ? rdata1 : rdata2;
        vectors++;
        if (got !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata%0d=%h, want %h", e.name, e.port, got, e.exp);
        end else $display("ok   %s: rdata%0d=%h", e.name, e.port, got);
      end
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    test_reset();
    test_write_read();
    test_r0();
    test_hazard();
    test_dual_read();
    test_back_to_back();
    test_random();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
